// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide unit for the EX stage: 32-cycle shift-add multiply and
// restoring divide on a shared accumulator, owning the architectural HI/LO registers.
module mdu_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            md_start,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] md_a,
  input  logic [XLEN-1:0] md_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  typedef enum logic [2:0] {
    OP_NONE = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3,
    OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6, OP_RSVD = 3'd7
  } op_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  logic              r_is_div, r_neg_q, r_neg_r, r_div0;
  logic [XLEN-1:0]   r_hi, r_lo;
  logic              r_busy, r_done;

  op_t               w_op;
  logic              w_is_md, w_is_div, w_signed;
  logic [XLEN-1:0]   w_abs_a, w_abs_b;
  logic [XLEN:0]     w_mul_sum, w_rem_sh, w_trial;
  logic [2*XLEN-1:0] w_acc_step, w_prod;
  logic [XLEN-1:0]   w_quo, w_rem;

  // NOTE: plain continuous assigns for all next-value logic, so no branch can leave a
  // combinational signal unassigned and infer a latch.
  assign w_op     = op_t'(md_op);
  assign w_is_md  = (w_op == OP_MULT) || (w_op == OP_MULTU) || (w_op == OP_DIV) || (w_op == OP_DIVU);
  assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
  assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
  assign w_abs_a  = (w_signed && md_a[XLEN-1]) ? -md_a : md_a;
  assign w_abs_b  = (w_signed && md_b[XLEN-1]) ? -md_b : md_b;

  // Multiply: add the multiplicand into the upper half when the current multiplier bit
  // (acc[0]) is set, then shift the whole accumulator right, carry included.
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, {XLEN{r_acc[0]}} & r_opnd};

  // Divide: shift {remainder, quotient} left; keep the trial subtraction if it didn't borrow.
  assign w_rem_sh = r_acc[2*XLEN-1:XLEN-1];
  assign w_trial  = w_rem_sh - {1'b0, r_opnd};

  assign w_acc_step = !r_is_div  ? {w_mul_sum, r_acc[XLEN-1:1]} :
                      !w_trial[XLEN] ? {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1} :
                                       {r_acc[2*XLEN-2:0], 1'b0};

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_div0 ? {XLEN{1'b1}} : (r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0]);
  assign w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  // NOTE: every register here uses non-blocking assignment so all state updates see
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (md_start && !flush) begin
            if (w_is_md) begin
              r_acc    <= {{XLEN{1'b0}}, w_is_div ? w_abs_a : w_abs_b};
              r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
              r_is_div <= w_is_div;
              r_neg_q  <= w_signed && (md_a[XLEN-1] ^ md_b[XLEN-1]);
              r_neg_r  <= w_signed && md_a[XLEN-1];
              r_div0   <= w_is_div && (md_b == '0);
              r_cnt    <= CW'(XLEN - 1);
              r_busy   <= 1'b1;
              r_state  <= CALC;
            end else if (w_op == OP_MTHI) begin
              r_hi <= md_a;
            end else if (w_op == OP_MTLO) begin
              r_lo <= md_a;
            end
          end
        end
        CALC: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) r_state <= FIX;
          end
        end
        FIX: begin
          if (!flush) begin
            r_hi   <= r_is_div ? w_rem : w_prod[2*XLEN-1:XLEN];
            r_lo   <= r_is_div ? w_quo : w_prod[XLEN-1:0];
            r_done <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed-vector bench for mdu_ctrl: latency, done pulse, HI/LO results, and the
// flush / ignored-start / async-reset corner cases.
module tb_mdu_ctrl;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            md_start;
  logic [2:0]      md_op;
  logic [XLEN-1:0] md_a, md_b;
  logic            flush;
  logic            busy, done;
  logic [XLEN-1:0] hi, lo;

  int n_vec  = 0;
  int n_miss = 0;

  mdu_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .md_start(md_start), .md_op(md_op),
    .md_a(md_a), .md_b(md_b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a start for one cycle; returns just after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    md_start = 1'b1; md_op = op; md_a = a; md_b = b;
    @(posedge clk); #1;
    md_start = 1'b0; md_op = 3'd0;
  endtask

  // Full MULT/DIV: checks 33-cycle busy window, single done pulse and results.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc = 0;
    int dn  = 0;
    issue(op, a, b);
    while (busy && cyc < 100) begin
      if (done) dn++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " busy_cycles"}, 64'(cyc), 64'd33);
    check({tag, " early_done"},  64'(dn), 64'd0);
    check({tag, " done"},        64'(done), 64'd1);
    check({tag, " hi"},          64'(hi), 64'(exp_hi));
    check({tag, " lo"},          64'(lo), 64'(exp_lo));
    @(posedge clk); #1;
    check({tag, " done_once"},   64'(done), 64'd0);
  endtask

  initial begin
    rst = 1'b1; md_start = 1'b0; md_op = 3'd0; md_a = '0; md_b = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("reset hi",   64'(hi), 64'd0);
    check("reset lo",   64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);

    issue(3'd6, 32'h1234_5678, 32'h0);
    check("mtlo lo",   64'(lo), 64'h1234_5678);
    check("mtlo busy", 64'(busy), 64'd0);
    check("mtlo done", 64'(done), 64'd0);
    issue(3'd5, 32'hCAFE_0001, 32'h0);
    check("mthi hi",   64'(hi), 64'hCAFE_0001);
    check("mthi lo",   64'(lo), 64'h1234_5678);

    // Start with flush in IDLE is dropped.
    @(posedge clk); #1;
    md_start = 1'b1; md_op = 3'd6; md_a = 32'hBAD0_BAD0; flush = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0; flush = 1'b0;
    check("flush_start lo",   64'(lo), 64'h1234_5678);
    check("flush_start busy", 64'(busy), 64'd0);

    run_md("mult -3*5",  3'd1, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_md("multu ff*ff",3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_md("mult -1*-1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1);
    run_md("div -7/2",   3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("div min/-1", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
    run_md("divu 55/0",  3'd4, 32'h55,        32'h0,         32'h55,        32'hFFFF_FFFF);
    run_md("div -9/0",   3'd3, 32'hFFFF_FFF7, 32'h0,         32'hFFFF_FFF7, 32'hFFFF_FFFF);

    // DIVU 7/2 with an MTHI presented mid-operation, which must be ignored.
    begin
      int cyc = 0;
      issue(3'd4, 32'd7, 32'd2);
      repeat (4) @(posedge clk);
      #1 md_start = 1'b1; md_op = 3'd5; md_a = 32'hDEAD_BEEF;
      @(posedge clk); #1 md_start = 1'b0; md_op = 3'd0;
      check("ign_mthi hi", 64'(hi), 64'hFFFF_FFF7);
      while (busy && cyc < 100) begin @(posedge clk); #1; cyc++; end
      check("divu 7/2 busy", 64'(busy), 64'd0);
      check("divu 7/2 hi",   64'(hi), 64'd1);
      check("divu 7/2 lo",   64'(lo), 64'd3);
    end

    // Flush at CALC cycle 10: no result, no done.
    begin
      int dn = 0;
      issue(3'd2, 32'd100, 32'd100);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      check("flush busy", 64'(busy), 64'd0);
      for (int i = 0; i < 40; i++) begin
        if (done) dn++;
        @(posedge clk); #1;
      end
      check("flush done", 64'(dn), 64'd0);
      check("flush hi",   64'(hi), 64'd1);
      check("flush lo",   64'(lo), 64'd3);
    end

    // Async reset at cycle 20 clears everything before the next edge.
    issue(3'd1, 32'd6, 32'd7);
    repeat (19) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst busy", 64'(busy), 64'd0);
    check("arst hi",   64'(hi), 64'd0);
    check("arst lo",   64'(lo), 64'd0);
    @(negedge clk) rst = 1'b0;
    run_md("mult 6*7",   3'd1, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Iterative multiply/divide controller for the MIPS pipeline's EX stage, sequencing MULT/MULTU/DIV/DIVU over 32 cycles with a shared shift/add-subtract datapath and owning the architectural HI/LO registers. The ALU performs only single-cycle ops. This block accepts one operation per start pulse and holds `busy` high so the hazard unit stalls the pipeline. It also services MTHI/MTLO writes, and drives HI/LO continuously for MFHI/MFLO forwarding.

## Interface
Parameters:
- `XLEN`, 32, operand width; the iteration count equals `XLEN`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `md_start`  in  1  request strobe; sampled only when `busy`=0.
- `md_op`  in  3  operation: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none).
- `md_a`  in  XLEN  rs operand (multiplicand / dividend / MTHI/MTLO data).
- `md_b`  in  XLEN  rt operand (multiplier / divisor).
- `flush`  in  1  abort the in-flight operation (branch/exception flush).
- `busy`  out  1  operation in progress; the pipeline stalls on MFHI/MFLO/MD ops.
- `done`  out  1  one-cycle pulse: HI/LO updated by a MULT/DIV.
- `hi`  out  XLEN  HI register.
- `lo`  out  XLEN  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, `md_start`=1:
  - op 1–4: latch magnitudes |a| and |b| (signed ops) or raw values (unsigned ops).
  - op 1–4: latch `neg_q` = sign(a) XOR sign(b) and `neg_r` = sign(a) (signed only).
  - op 1–4: load counter = XLEN−1, go to CALC, set `busy`.
  - op 5: write `hi` = `md_a`. op 6: write `lo` = `md_a`. Both take one cycle, leave `busy` at 0, and do not pulse `done`.
  - op 0 or 7: no effect.
- CALC, multiply: shift-add, one multiplier bit per cycle, into a 2·XLEN accumulator.
- CALC, divide: restoring divide, one quotient bit per cycle.
- CALC: counter decrements each cycle; when it reaches 0, go to FIX.
- FIX:
  - Multiply result: negate the 64-bit product if `neg_q`. Write HI=upper half, LO=lower half.
  - Divide result: LO = quotient, negated if `neg_q`. HI = remainder, negated if `neg_r`.
  - Then clear `busy`, pulse `done` on the next cycle, return to IDLE.
- All arithmetic is unsigned, modulo 2^XLEN per half. Negation is two's complement over the full result width.
- Divide by zero, signed or unsigned: LO = all ones, HI = `md_a` unmodified. The block still takes the full latency; no trap.
- Signed 0x80000000 / −1: LO=0x80000000, HI=0 (falls out of the magnitude algorithm).
- `md_start` while `busy`=1 is ignored, including MTHI/MTLO. The hazard unit must not issue these while busy.
- `flush` in CALC or FIX: return to IDLE next edge, `busy`=0, no `done`, HI/LO unchanged. `flush` in IDLE: no effect. `flush` together with `md_start` in IDLE: the start is dropped.
- `rst` mid-operation: immediate return to IDLE; HI/LO cleared.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- Start accepted at edge E0:
  - `busy` is high from E0 through the cycle ending at edge E0+33: 32 CALC cycles plus 1 FIX cycle.
  - `hi`/`lo` take the new value at E0+33.
  - `done`=1 for the cycle after E0+33.
  - The earliest next accepted start is at edge E0+34. `busy` deasserts at E0+33, so a start presented that cycle is accepted.
- MTHI/MTLO: `hi`/`lo` update at the accepting edge; readable the following cycle.
- `hi`/`lo` are registered outputs with no combinational path from inputs.

## Test plan
- Reset then idle: `hi`=`lo`=0, `busy`=0. MTLO 0x12345678 → `lo`=0x12345678 the next cycle, `busy` stays 0, no `done`.
- MULT a=−3 (0xFFFFFFFD), b=5:
  - `busy` high exactly 33 cycles.
  - HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - `done` pulses once.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
  - Then MULT with the same operands → HI=0, LO=1.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/2 → LO=3, HI=1.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 0x55/0 → LO=0xFFFFFFFF, HI=0x55 after 33 cycles.
- Mid-operation events:
  - `flush` at CALC cycle 10 → `busy`=0 next cycle, HI/LO unchanged, no `done`.
  - `md_start` MTHI during `busy` → ignored.
  - Async `rst` at cycle 20 → outputs zero immediately.
